// File: rtl/seq_multiplier_if.sv
// seq_multiplier_if
//   Operand/result handshake bundle for the iterative multiplier.
//   master : the requester (drives operands, mode and out_ready)
//   slave  : the multiplier (drives in_ready, out_valid, product, busy)
// Signals:
//   in_valid  / in_ready   operand handshake
//   a, b, is_signed        operands and signed/unsigned mode
//   out_valid / out_ready  result handshake
//   product                full 2*DATA_WIDTH result
//   busy                   operation in flight or result pending
interface seq_multiplier_if #(
    parameter int DATA_WIDTH = 8
) ();

    logic                      in_valid;
    logic                      in_ready;
    logic [DATA_WIDTH-1:0]     a;
    logic [DATA_WIDTH-1:0]     b;
    logic                      is_signed;
    logic                      out_valid;
    logic                      out_ready;
    logic [2*DATA_WIDTH-1:0]   product;
    logic                      busy;

    modport master (
        output in_valid,
        output a,
        output b,
        output is_signed,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  product,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  is_signed,
        input  out_ready,
        output in_ready,
        output out_valid,
        output product,
        output busy
    );

endinterface

// File: rtl/seq_multiplier.sv
// seq_multiplier
//   Radix-2 shift-add multiplier, one partial-product step per clock.
//   Signed operands are converted to magnitudes on acceptance and the
//   result is negated on the last step when the operand signs differ.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    seq_multiplier_if.slave (operand and result handshakes)
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | in_ready high, waiting for operands
// RUN   | one shift-add step per cycle, DATA_WIDTH steps total
// DONE  | out_valid high, product held until out_ready
module seq_multiplier #(
    parameter int DATA_WIDTH = 8   // legal range 2..32
) (
    input  logic             clk,
    input  logic             rst_n,
    seq_multiplier_if.slave  bus
);

    localparam int DW = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DW-1:0]     mcand_q, mcand_d;
    // Upper half is the running partial sum, lower half holds the
    // not-yet-consumed multiplier bits; after DW shifts it is the product.
    logic [2*DW-1:0]   acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              neg_q, neg_d;
    logic [2*DW-1:0]   product_q, product_d;

    logic [DW-1:0]     mag_a;
    logic [DW-1:0]     mag_b;
    logic [DW:0]       sum;
    logic [2*DW-1:0]   acc_step;

    // -2^(DW-1) negates to itself, which is the correct unsigned magnitude.
    always_comb begin
        mag_a = bus.a;
        mag_b = bus.b;
        if (bus.is_signed && bus.a[DW-1]) begin
            mag_a = -bus.a;
        end
        if (bus.is_signed && bus.b[DW-1]) begin
            mag_b = -bus.b;
        end
    end

    always_comb begin
        sum = {1'b0, acc_q[2*DW-1:DW]};
        if (acc_q[0]) begin
            sum = {1'b0, acc_q[2*DW-1:DW]} + {1'b0, mcand_q};
        end
        acc_step = {sum, acc_q[DW-1:1]};
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        product_d = product_q;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    mcand_d = mag_a;
                    acc_d   = {{DW{1'b0}}, mag_b};
                    cnt_d   = CW'(DW);
                    neg_d   = bus.is_signed & (bus.a[DW-1] ^ bus.b[DW-1]);
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = acc_step;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    product_d = neg_q ? -acc_step : acc_step;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            product_q <= product_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.product   = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
module tb_seq_multiplier;

    logic clk;
    logic rst_n;

    int tests_run = 0;
    int tests_failed = 0;

    seq_multiplier_if #(.DATA_WIDTH(8))  if8  ();
    seq_multiplier_if #(.DATA_WIDTH(16)) if16 ();

    seq_multiplier #(.DATA_WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if8)
    );

    seq_multiplier #(.DATA_WIDTH(16)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: interpret operands as w-bit integers, multiply, keep 2w bits.
    function automatic logic [63:0] ref_mul(input int w, input logic [31:0] a,
                                            input logic [31:0] b, input bit sgn);
        longint va, vb, p;
        logic [63:0] mask;
        mask = (64'd1 << (2 * w)) - 64'd1;
        va = longint'(a) & ((longint'(1) << w) - 1);
        vb = longint'(b) & ((longint'(1) << w) - 1);
        if (sgn && a[w-1]) va = va - (longint'(1) << w);
        if (sgn && b[w-1]) vb = vb - (longint'(1) << w);
        p = va * vb;
        return 64'(p) & mask;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int w, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input bit s);
        if (w == 8) begin
            if8.in_valid  = v;
            if8.a         = a[7:0];
            if8.b         = b[7:0];
            if8.is_signed = s;
        end else begin
            if16.in_valid  = v;
            if16.a         = a[15:0];
            if16.b         = b[15:0];
            if16.is_signed = s;
        end
    endtask

    function automatic logic ov(input int w);
        return (w == 8) ? if8.out_valid : if16.out_valid;
    endfunction

    function automatic logic ir(input int w);
        return (w == 8) ? if8.in_ready : if16.in_ready;
    endfunction

    function automatic logic bz(input int w);
        return (w == 8) ? if8.busy : if16.busy;
    endfunction

    function automatic logic [63:0] prod(input int w);
        return (w == 8) ? 64'(if8.product) : 64'(if16.product);
    endfunction

    // One full operation with out_ready high: latency, product, return to IDLE.
    task automatic do_op(input int w, input logic [31:0] a, input logic [31:0] b,
                         input bit s, input string tag);
        int k;
        @(negedge clk);
        check({tag, "_in_ready"}, 64'(ir(w)), 64'd1);
        drive(w, 1'b1, a, b, s);
        @(posedge clk);
        #1;
        drive(w, 1'b0, a, b, s);
        for (int i = 1; i <= w; i++) begin
            @(posedge clk);
            #1;
            if (i < w) begin
                if (i == 1 || i == w - 1)
                    check({tag, "_run_flags"}, {62'd0, ov(w), ir(w)}, 64'd0);
            end
        end
        check({tag, "_latency"}, 64'(ov(w)), 64'd1);
        k = 0;
        while (!ov(w) && k < 4 * w) begin
            @(posedge clk);
            #1;
            k++;
        end
        check({tag, "_product"}, prod(w), ref_mul(w, a, b, s));
        @(posedge clk);
        #1;
        check({tag, "_back_idle"}, {62'd0, ir(w), ov(w)}, 64'd2);
    endtask

    initial begin
        logic [31:0] ra, rb;
        bit rs;

        rst_n = 1'b0;
        if8.out_ready  = 1'b1;
        if16.out_ready = 1'b1;
        drive(8, 1'b0, 32'd0, 32'd0, 1'b0);
        drive(16, 1'b0, 32'd0, 32'd0, 1'b0);

        #12;
        check("rst_in_ready", 64'(if8.in_ready), 64'd1);
        check("rst_out_valid", 64'(if8.out_valid), 64'd0);
        check("rst_busy", 64'(if8.busy), 64'd0);
        check("rst_product", 64'(if8.product), 64'd0);
        check("rst_product16", 64'(if16.product), 64'd0);

        @(negedge clk);
        rst_n = 1'b1;

        do_op(8, 32'd13, 32'd11, 1'b0, "u13x11");
        check("u13x11_const", prod(8), 64'h008F);
        do_op(8, 32'd255, 32'd255, 1'b0, "u255x255");
        do_op(8, 32'd0, 32'd200, 1'b0, "u0x200");
        do_op(8, 32'hFD, 32'h05, 1'b1, "s_m3x5");
        check("s_m3x5_const", prod(8), 64'hFFF1);
        do_op(8, 32'h80, 32'h80, 1'b1, "s_m128xm128");
        do_op(8, 32'h7F, 32'h80, 1'b1, "s_127xm128");
        do_op(8, 32'h80, 32'h80, 1'b0, "u128x128");

        for (int n = 0; n < 24; n++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            do_op(8, ra, rb, rs, "rand8");
        end

        // Backpressure with an ignored operand pulse during RUN.
        if8.out_ready = 1'b0;
        @(negedge clk);
        check("bp_in_ready", 64'(if8.in_ready), 64'd1);
        drive(8, 1'b1, 32'd200, 32'd3, 1'b0);
        @(posedge clk);
        #1;
        drive(8, 1'b0, 32'd200, 32'd3, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        drive(8, 1'b1, 32'd7, 32'd9, 1'b0);
        @(posedge clk);
        #1;
        drive(8, 1'b0, 32'd7, 32'd9, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("bp_latency", 64'(if8.out_valid), 64'd1);
        check("bp_product", 64'(if8.product), ref_mul(8, 32'd200, 32'd3, 1'b0));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold_valid", 64'(if8.out_valid), 64'd1);
            check("bp_hold_product", 64'(if8.product), 64'd600);
        end
        if8.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_in_ready", 64'(if8.in_ready), 64'd1);
        check("bp_release_busy", {62'd0, if8.busy, if8.out_valid}, 64'd0);

        // Reset at step 4 of 25 x 4.
        @(negedge clk);
        drive(8, 1'b1, 32'd25, 32'd4, 1'b0);
        @(posedge clk);
        #1;
        drive(8, 1'b0, 32'd25, 32'd4, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("mid_busy_before_rst", 64'(if8.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(if8.out_valid), 64'd0);
        check("mid_rst_product", 64'(if8.product), 64'd0);
        check("mid_rst_busy", 64'(if8.busy), 64'd0);
        check("mid_rst_in_ready", 64'(if8.in_ready), 64'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(8, 32'd6, 32'd7, 1'b0, "after_rst_6x7");
        check("after_rst_const", prod(8), 64'h002A);

        // 16-bit build.
        do_op(16, 32'hFFFF, 32'hFFFF, 1'b0, "w16_uffff");
        check("w16_uffff_const", prod(16), 64'hFFFE0001);
        do_op(16, 32'h8000, 32'h0001, 1'b1, "w16_s8000x1");
        check("w16_s8000x1_const", prod(16), 64'hFFFF8000);
        for (int n = 0; n < 6; n++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            do_op(16, ra, rb, rs, "rand16");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
